// File: rtl/audio_fifo_pkg.sv
// Shared register map, bit positions and constants for the audio sample FIFO.
package audio_fifo_pkg;

  localparam logic [23:0] OFF_DATA   = 24'h00_0000;
  localparam logic [23:0] OFF_STATUS = 24'h00_0004;
  localparam logic [23:0] OFF_CTRL   = 24'h00_0008;

  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_UDR   = 19;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_IRQ = 2;

  localparam logic [11:0] MIDSCALE = 12'h800;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [23:0] off);
    case (off)
      OFF_DATA:   return REG_DATA;
      OFF_STATUS: return REG_STATUS;
      OFF_CTRL:   return REG_CTRL;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head word is always visible on rdata.
module sync_fifo #(
  parameter  int DW    = 12,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign rd_en = pop && !empty && !flush;
  assign wr_en = push && !flush && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_fifo.sv
// Memory-mapped sample FIFO feeding a DAC at a fixed sample rate.
// Build option AUDIO_FIFO_IRQ_EN adds CTRL[2] irq_enable and the low-water irq_low output.
module audio_sample_fifo
  import audio_fifo_pkg::*;
#(
  parameter logic [7:0] BASE       = 8'h04,
  parameter int         DEPTH      = 16,
  parameter int         SAMPLE_DIV = 2000,
  parameter int         IRQ_LEVEL  = DEPTH / 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [11:0] sample_out,
  output logic        irq_low
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(SAMPLE_DIV);

  reg_sel_e      rsel;
  logic          sel;
  logic          wr;
  logic          push;
  logic          ctrl_wr;
  logic          stat_wr;
  logic          flush;
  logic          tick;
  logic          pop;
  logic          enable;
  logic          irq_en;
  logic          overflow;
  logic          underrun;
  logic [TW-1:0] tick_cnt;
  logic [11:0]   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   rd_val;
  logic          unused_wdata;

  assign sel     = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE);
  assign wr      = |iomem_wstrb;
  assign rsel    = decode_reg(iomem_addr[23:0]);
  assign push    = sel && wr && (rsel == REG_DATA) && (iomem_wstrb[0] || iomem_wstrb[1]);
  assign ctrl_wr = sel && wr && (rsel == REG_CTRL);
  assign stat_wr = sel && wr && (rsel == REG_STATUS);
  assign flush   = ctrl_wr && iomem_wdata[CTRL_CLR];

  assign tick = enable && (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign pop  = tick && !fifo_empty;

  assign unused_wdata = ^{iomem_wdata[31:20], iomem_wdata[17:12], iomem_wdata[2]};

  sync_fifo #(
    .DW    (12),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (iomem_wdata[11:0]),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_val = '0;
    case (rsel)
      REG_STATUS: begin
        rd_val[8:0]     = 9'(fifo_count);
        rd_val[ST_EMPTY] = fifo_empty;
        rd_val[ST_FULL]  = fifo_full;
        rd_val[ST_OVF]   = overflow;
        rd_val[ST_UDR]   = underrun;
      end
      REG_CTRL: begin
        rd_val[CTRL_EN]  = enable;
        rd_val[CTRL_IRQ] = irq_en;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      enable      <= 1'b0;
      tick_cnt    <= '0;
      overflow    <= 1'b0;
      underrun    <= 1'b0;
      sample_out  <= MIDSCALE;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= (sel && !wr) ? rd_val : '0;
      if (ctrl_wr) enable <= iomem_wdata[CTRL_EN];
      if (!enable || tick) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + 1'b1;
      // A flag event in the same cycle as its clear wins.
      overflow <= (push && fifo_full && !pop) || (overflow && !(stat_wr && iomem_wdata[ST_OVF]));
      underrun <= (tick && fifo_empty) || (underrun && !(stat_wr && iomem_wdata[ST_UDR]));
      if (flush)    sample_out <= MIDSCALE;
      else if (pop) sample_out <= head;
    end
  end

`ifdef AUDIO_FIFO_IRQ_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en  <= 1'b0;
      irq_low <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= iomem_wdata[CTRL_IRQ];
      irq_low <= irq_en && enable && (fifo_count <= CW'(IRQ_LEVEL));
    end
  end
`else
  assign irq_en  = 1'b0;
  assign irq_low = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed scenarios plus random bus traffic
// compared cycle by cycle against a queue-based reference model.
module tb_audio_sample_fifo;

  localparam int         DIV   = 4;
  localparam int         DEPTH = 4;
  localparam int         LVL   = 1;
  localparam logic [7:0] BASE  = 8'h04;
`ifdef AUDIO_FIFO_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [11:0] sample_out;
  logic        irq_low;

  audio_sample_fifo #(
    .BASE      (BASE),
    .DEPTH     (DEPTH),
    .SAMPLE_DIV(DIV),
    .IRQ_LEVEL (LVL)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(valid),
    .iomem_ready(ready),
    .iomem_wstrb(wstrb),
    .iomem_addr (addr),
    .iomem_wdata(wdata),
    .iomem_rdata(rdata),
    .sample_out (sample_out),
    .irq_low    (irq_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: the FIFO is a queue, ticks are derived from the cycle the
  // sampler was switched on, and every effect is computed from pre-edge state.
  logic [11:0] mq[$];
  logic [11:0] m_sample;
  logic [31:0] m_rdata;
  bit          m_ovf, m_udr, m_en, m_irq_en, m_irq, m_ready;
  int          m_cyc;
  int          m_en_since;

  task automatic model_reset();
    mq.delete();
    m_sample   = 12'h800;
    m_rdata    = '0;
    m_ovf      = 0;
    m_udr      = 0;
    m_en       = 0;
    m_irq_en   = 0;
    m_irq      = 0;
    m_ready    = 0;
    m_en_since = 0;
  endtask

  task automatic model_step();
    bit          sel, wr, tick, set_ovf, set_udr, clr_ovf, clr_udr;
    logic [23:0] off;
    logic [31:0] rv;
    m_cyc++;
    if (!resetn) begin
      model_reset();
      return;
    end
    sel  = valid && !m_ready && (addr[31:24] == BASE);
    wr   = (wstrb != 4'h0);
    off  = addr[23:0];
    tick = m_en && (((m_cyc - m_en_since) % DIV) == DIV - 1);
    rv   = '0;
    if (off == 24'h4)
      rv = {12'h0, m_udr, m_ovf, mq.size() == DEPTH, mq.size() == 0, 7'h0, 9'(mq.size())};
    else if (off == 24'h8)
      rv = {29'h0, m_irq_en, 1'b0, m_en};
    m_irq   = m_irq_en && m_en && (mq.size() <= LVL);
    m_rdata = (sel && !wr) ? rv : 32'h0;
    m_ready = sel;
    set_udr = tick && (mq.size() == 0);
    if (tick && mq.size() != 0) m_sample = mq.pop_front();
    set_ovf = 0;
    if (sel && wr && off == 24'h0 && (wstrb[0] || wstrb[1])) begin
      if (mq.size() < DEPTH) mq.push_back(wdata[11:0]);
      else set_ovf = 1;
    end
    clr_ovf = sel && wr && off == 24'h4 && wdata[18];
    clr_udr = sel && wr && off == 24'h4 && wdata[19];
    m_ovf = (m_ovf && !clr_ovf) || set_ovf;
    m_udr = (m_udr && !clr_udr) || set_udr;
    if (sel && wr && off == 24'h8) begin
      if (wdata[0] && !m_en) m_en_since = m_cyc + 1;
      m_en = wdata[0];
      if (IRQ_BUILD) m_irq_en = wdata[2];
      if (wdata[1]) begin
        mq.delete();
        m_sample = 12'h800;
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
    check_eq("sample_out", 32'(sample_out), 32'(m_sample));
    check_eq("ready", 32'(ready), 32'(m_ready));
    check_eq("irq_low", 32'(irq_low), 32'(m_irq));
    if (m_ready) check_eq("rdata", rdata, m_rdata);
  endtask

  task automatic bus(input bit wr_op, input logic [7:0] base, input logic [23:0] off,
                     input logic [31:0] data, input logic [3:0] strb, output logic [31:0] rd);
    valid = 1'b1;
    addr  = {base, off};
    wdata = data;
    wstrb = wr_op ? strb : 4'h0;
    tick_clk();
    rd    = rdata;
    valid = 1'b0;
    wstrb = 4'h0;
    tick_clk();
  endtask

  task automatic wr_reg(input logic [23:0] off, input logic [31:0] data);
    logic [31:0] dummy;
    bus(1'b1, BASE, off, data, 4'hF, dummy);
  endtask

  task automatic rd_reg(input logic [23:0] off, output logic [31:0] rd);
    bus(1'b0, BASE, off, 32'h0, 4'h0, rd);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    valid  = 1'b0;
    wstrb  = 4'h0;
    tick_clk();
    tick_clk();
    resetn = 1'b1;
  endtask

  logic [11:0] seen[$];

  task automatic collect(input int n, input int budget);
    logic [11:0] last;
    seen.delete();
    last = sample_out;
    for (int i = 0; i < budget && seen.size() < n; i++) begin
      tick_clk();
      if (sample_out != last) begin
        seen.push_back(sample_out);
        last = sample_out;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] d;
    int          r;
    resetn = 1'b0;
    valid  = 1'b0;
    addr   = '0;
    wdata  = '0;
    wstrb  = 4'h0;
    m_cyc  = 0;
    model_reset();

    // Reset state
    apply_reset();
    check_eq("rst_sample", 32'(sample_out), 32'h800);
    check_eq("rst_ready", 32'(ready), 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    rd_reg(24'h4, rd);
    check_eq("rst_status", rd, 32'h0001_0000);
    rd_reg(24'h8, rd);
    check_eq("rst_ctrl", rd, 32'h0);

    // Three samples played back at the tick rate, then underrun
    wr_reg(24'h0, 32'h100);
    wr_reg(24'h0, 32'h200);
    wr_reg(24'h0, 32'h300);
    wr_reg(24'h8, 32'h1);
    repeat (2) tick_clk();
    check_eq("play_pre", 32'(sample_out), 32'h800);
    tick_clk();
    check_eq("play_1", 32'(sample_out), 32'h100);
    repeat (4) tick_clk();
    check_eq("play_2", 32'(sample_out), 32'h200);
    repeat (4) tick_clk();
    check_eq("play_3", 32'(sample_out), 32'h300);
    repeat (4) tick_clk();
    check_eq("play_hold", 32'(sample_out), 32'h300);
    rd_reg(24'h4, rd);
    check_eq("play_status", rd, 32'h0009_0000);

    // Overflow: fifth push dropped
    apply_reset();
    wr_reg(24'h0, 32'h111);
    wr_reg(24'h0, 32'h222);
    wr_reg(24'h0, 32'h333);
    wr_reg(24'h0, 32'h444);
    wr_reg(24'h0, 32'h555);
    rd_reg(24'h4, rd);
    check_eq("ovf_status", rd, 32'h0006_0004);
    wr_reg(24'h8, 32'h1);
    collect(4, 30);
    check_eq("ovf_nseen", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) check_eq("ovf_4th", 32'(seen[3]), 32'h444);
    repeat (8) tick_clk();
    check_eq("ovf_no5th", 32'(sample_out), 32'h444);

    // Sticky flag clear, then clear racing a set
    wr_reg(24'h8, 32'h0);
    rd_reg(24'h4, rd);
    check_eq("flags_set", rd, 32'h000D_0000);
    wr_reg(24'h4, 32'h000C_0000);
    rd_reg(24'h4, rd);
    check_eq("flags_clr", rd, 32'h0001_0000);
    wr_reg(24'h8, 32'h1);
    repeat (2) tick_clk();
    wr_reg(24'h4, 32'h000C_0000);
    rd_reg(24'h4, rd);
    check_eq("flags_setwins", rd, 32'h0009_0000);
    wr_reg(24'h8, 32'h0);

    // Push into a full FIFO on the tick cycle is accepted
    apply_reset();
    wr_reg(24'h0, 32'hA01);
    wr_reg(24'h0, 32'hA02);
    wr_reg(24'h0, 32'hA03);
    wr_reg(24'h0, 32'hA04);
    wr_reg(24'h8, 32'h1);
    repeat (2) tick_clk();
    wr_reg(24'h0, 32'hA05);
    check_eq("coin_first", 32'(sample_out), 32'hA01);
    rd_reg(24'h4, rd);
    check_eq("coin_status", rd, 32'h0002_0004);
    collect(4, 30);
    check_eq("coin_nseen", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) check_eq("coin_4th", 32'(seen[3]), 32'hA05);

    // Low-water interrupt
    apply_reset();
    wr_reg(24'h0, 32'h0B1);
    wr_reg(24'h0, 32'h0B2);
    wr_reg(24'h8, 32'h5);
    repeat (3) tick_clk();
    check_eq("irq_before", 32'(irq_low), 32'h0);
    check_eq("irq_sample", 32'(sample_out), 32'h0B1);
    tick_clk();
    check_eq("irq_after", 32'(irq_low), 32'(IRQ_BUILD));
    rd_reg(24'h8, rd);
    check_eq("irq_ctrl", rd, IRQ_BUILD ? 32'h5 : 32'h1);

    // Asynchronous reset while a read is being acknowledged
    valid = 1'b1;
    addr  = {BASE, 24'h4};
    wstrb = 4'h0;
    tick_clk();
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_ready", 32'(ready), 32'h0);
    check_eq("arst_rdata", rdata, 32'h0);
    check_eq("arst_sample", 32'(sample_out), 32'h800);
    check_eq("arst_irq", 32'(irq_low), 32'h0);
    apply_reset();
    rd_reg(24'h4, rd);
    check_eq("arst_status", rd, 32'h0001_0000);

    // Random traffic against the model
    apply_reset();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        bus(1'b1, BASE, 24'h0, $urandom, 4'($urandom_range(1, 15)), rd);
      end else if (r < 40) begin
        rd_reg(24'h4, rd);
      end else if (r < 48) begin
        wr_reg(24'h4, $urandom & 32'h000C_0000);
      end else if (r < 56) begin
        d = $urandom & 32'h5;
        d[0] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) d[1] = 1'b1;
        wr_reg(24'h8, d);
      end else if (r < 60) begin
        rd_reg(24'h8, rd);
      end else if (r < 64) begin
        bus($urandom_range(0, 1) == 1, BASE, ($urandom_range(0, 1) == 1) ? 24'h0C : 24'h0,
            $urandom, 4'hC, rd);
      end else if (r < 68) begin
        bus($urandom_range(0, 1) == 1, 8'h05, 24'h0, $urandom, 4'hF, rd);
      end else if (r < 70) begin
        apply_reset();
      end else begin
        repeat ($urandom_range(1, 6)) tick_clk();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
